// File: rtl/mult_div_seq_if.sv
// Control-unit <-> mult/div sequencer bus: start strobes and operands in, status and HI/LO out.
interface mult_div_seq_if #(parameter int WIDTH = 32);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (output mult_start, div_start, op_a, op_b,
                    input  busy, done, div_zero, hi_out, lo_out);
    modport slave  (input  mult_start, div_start, op_a, op_b,
                    output busy, done, div_zero, hi_out, lo_out);
endinterface

// File: rtl/mult_div_seq.sv
// Multicycle signed mult (radix-2 Booth) / div (restoring on magnitudes) sequencer owning HI/LO.
// The first iteration is folded into the start edge so the latency matches the control unit's wait state.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 2);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    state_t             state, state_nx;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand, dvs, rem, quo, hi, lo;
    logic               neg_q, neg_r, dz;
    logic [CW-1:0]      cnt;

    // One Booth step: add/sub multiplicand on a sign-extended upper half, then arithmetic shift.
    function automatic logic [2*WIDTH:0] booth_step(input logic [2*WIDTH:0] a,
                                                    input logic [WIDTH-1:0] m);
        logic [WIDTH:0] up, sum;
        up = {a[2*WIDTH], a[2*WIDTH:WIDTH+1]};
        case (a[1:0])
            2'b01:   sum = up + {m[WIDTH-1], m};
            2'b10:   sum = up - {m[WIDTH-1], m};
            default: sum = up;
        endcase
        return {sum, a[WIDTH:1]};
    endfunction

    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] r_nx;
        diff = {r, q[WIDTH-1]} - {1'b0, d};
        r_nx = diff[WIDTH] ? {r[WIDTH-2:0], q[WIDTH-1]} : diff[WIDTH-1:0];
        return {r_nx, q[WIDTH-2:0], ~diff[WIDTH]};
    endfunction

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH:0]   mul_init, mul_next;
    logic [2*WIDTH-1:0] div_init, div_next;
    logic               b_zero;

    assign a_mag    = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
    assign b_mag    = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
    assign b_zero   = (bus.op_b == '0);
    assign mul_init = booth_step({{WIDTH{1'b0}}, bus.op_b, 1'b0}, bus.op_a);
    assign mul_next = booth_step(acc, mcand);
    assign div_init = div_step('0, a_mag, b_mag);
    assign div_next = div_step(rem, quo, dvs);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.mult_start)     state_nx = MULT;
                else if (bus.div_start) state_nx = b_zero ? DONE : DIV;
            end
            MULT:    if (cnt == '0) state_nx = DONE;
            DIV:     if (cnt == '0) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            mcand <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            hi    <= '0;
            lo    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mult_start) begin
                        mcand <= bus.op_a;
                        acc   <= mul_init;
                        cnt   <= CNT_INIT;
                        dz    <= 1'b0;
                    end else if (bus.div_start) begin
                        dvs          <= b_mag;
                        {rem, quo}   <= div_init;
                        neg_q        <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                        neg_r        <= bus.op_a[WIDTH-1];
                        cnt          <= CNT_INIT;
                        dz           <= b_zero;
                    end
                end
                MULT: begin
                    acc <= mul_next;
                    if (cnt == '0) {hi, lo} <= mul_next[2*WIDTH:1];
                    else           cnt <= cnt - 1'b1;
                end
                DIV: begin
                    {rem, quo} <= div_next;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                // Remainder follows the dividend's sign; quotient truncates toward zero.
                FIX: begin
                    hi <= neg_r ? -rem : rem;
                    lo <= neg_q ? -quo : quo;
                end
                DONE:    dz <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == MULT) || (state == DIV) || (state == FIX);
    assign bus.done     = (state == DONE);
    assign bus.div_zero = (state == DONE) && dz;
    assign bus.hi_out   = hi;
    assign bus.lo_out   = lo;
endmodule

// File: tb/tb_mult_div_seq.sv
// Directed vectors for mult_div_seq: result, latency, busy length and div_zero per operation,
// plus reset-abort and start-while-busy sequences.
module tb_mult_div_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_seq_if #(.WIDTH(W)) bus();
    mult_div_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // op: 0 = mult, 1 = div, 2 = both starts high
    typedef struct {
        int          op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
        int          lat, bsy;
    } vec_t;

    vec_t vt[13];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bsy, output logic dz_seen, output bit to);
        @(negedge clk);
        bus.op_a       = a;
        bus.op_b       = b;
        bus.mult_start = (op != 1);
        bus.div_start  = (op != 0);
        @(posedge clk);
        #1;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.op_a       = ~a;
        bus.op_b       = 32'h0;
        lat = 0; bsy = 0; dz_seen = 1'b0; to = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.busy) bsy++;
            if (bus.done) begin
                lat = i; dz_seen = bus.div_zero; to = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int   lat, bsy, ndone, first;
        logic dzs;
        bit   to;
        logic [31:0] hi_c, lo_c;

        vt[0]  = '{0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32, 31};
        vt[1]  = '{0, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 32, 31};
        vt[2]  = '{0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32, 31};
        vt[3]  = '{0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 32, 31};
        vt[4]  = '{0, 32'h00010000,   32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 32, 31};
        vt[5]  = '{1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 32};
        vt[6]  = '{1, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 32};
        vt[7]  = '{1, 32'd100,        32'd7,        32'h00000002, 32'h0000000E, 1'b0, 33, 32};
        vt[8]  = '{1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 33, 32};
        vt[9]  = '{1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 32};
        // 1628201331 * 805654952 = 0x12345678_12345678, presets HI/LO for the zero-divisor case
        vt[10] = '{0, 32'd1628201331, 32'd805654952, 32'h12345678, 32'h12345678, 1'b0, 32, 31};
        vt[11] = '{1, 32'd5,          32'd0,        32'h12345678, 32'h12345678, 1'b1, 1, 0};
        vt[12] = '{2, 32'd3,          32'd5,        32'h00000000, 32'h0000000F, 1'b0, 32, 31};

        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        reset          = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset busy",     {63'd0, bus.busy},     64'd0);
        chk("reset done",     {63'd0, bus.done},     64'd0);
        chk("reset div_zero", {63'd0, bus.div_zero}, 64'd0);
        chk("reset hi",       {32'd0, bus.hi_out},   64'd0);
        chk("reset lo",       {32'd0, bus.lo_out},   64'd0);
        reset = 1'b0;

        for (int v = 0; v < 13; v++) begin
            run_op(vt[v].op, vt[v].a, vt[v].b, lat, bsy, dzs, to);
            chk($sformatf("v%0d timeout", v),  {63'd0, to},          64'd0);
            chk($sformatf("v%0d latency", v),  64'(lat),             64'(vt[v].lat));
            chk($sformatf("v%0d busy", v),     64'(bsy),             64'(vt[v].bsy));
            chk($sformatf("v%0d div_zero", v), {63'd0, dzs},         {63'd0, vt[v].dz});
            chk($sformatf("v%0d hi", v),       {32'd0, bus.hi_out},  {32'd0, vt[v].hi});
            chk($sformatf("v%0d lo", v),       {32'd0, bus.lo_out},  {32'd0, vt[v].lo});
        end

        // Reset during cycle 10 of a multiply: abort, clear HI/LO, no done afterwards.
        @(negedge clk);
        bus.op_a = 32'd7; bus.op_b = 32'd9; bus.mult_start = 1'b1;
        @(posedge clk);
        #1;
        bus.mult_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid busy before reset", {63'd0, bus.busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("abort busy", {63'd0, bus.busy},   64'd0);
        chk("abort hi",   {32'd0, bus.hi_out}, 64'd0);
        chk("abort lo",   {32'd0, bus.lo_out}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);

        // Second start (both strobes, zero divisor) while busy must be ignored.
        @(negedge clk);
        bus.op_a = 32'd2; bus.op_b = 32'd3; bus.mult_start = 1'b1;
        @(posedge clk);
        #1;
        bus.mult_start = 1'b0;
        ndone = 0; first = 0; dzs = 1'b0; hi_c = '0; lo_c = '0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (bus.div_zero) dzs = 1'b1;
            if (bus.done) begin
                ndone++;
                if (first == 0) begin
                    first = i; hi_c = bus.hi_out; lo_c = bus.lo_out;
                end
            end
            if (i == 5) begin
                bus.mult_start = 1'b1; bus.div_start = 1'b1;
                bus.op_a = 32'd100; bus.op_b = 32'd0;
            end else begin
                bus.mult_start = 1'b0; bus.div_start = 1'b0;
            end
        end
        chk("busy-start done count", 64'(ndone),     64'd1);
        chk("busy-start latency",    64'(first),     64'd32);
        chk("busy-start div_zero",   {63'd0, dzs},   64'd0);
        chk("busy-start hi",         {32'd0, hi_c},  64'd0);
        chk("busy-start lo",         {32'd0, lo_c},  64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
